// File: rtl/sm3_axis_pad.sv
// sm3_axis_pad: AXI-Stream byte-message front end for the SM3 compression core.
// Packs big-endian stream beats into 512-bit blocks, appends the SM3 padding
// (0x80, zero fill, 64-bit big-endian bit length) and hands blocks to the core
// with first/last markers. Messages of any length, including empty, are supported.
module sm3_axis_pad #(
  parameter int DATA_W = 32
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [DATA_W-1:0]     s_axis_tdata,
  input  logic [DATA_W/8-1:0]   s_axis_tkeep,
  input  logic                  s_axis_tlast,
  input  logic                  s_axis_tvalid,
  output logic                  s_axis_tready,
  output logic [511:0]          blk_data,
  output logic                  blk_valid,
  input  logic                  blk_ready,
  output logic                  blk_first,
  output logic                  blk_last,
  output logic                  err_keep
);

  localparam int BYTES = DATA_W / 8;
  localparam int KW    = $clog2(BYTES + 1);

  typedef enum logic [1:0] {
    ST_FILL = 2'd0,  // accepting stream beats
    ST_EMIT = 2'd1,  // presenting a block to the core
    ST_PAD  = 2'd2,  // one cycle: place 0x80 (and length if it fits)
    ST_PAD2 = 2'd3   // one cycle: build the extra length-only block
  } state_t;

  state_t        state_q, state_d;
  logic [511:0]  buf_q, buf_d;     // block under construction, byte 0 in [511:504]
  logic [6:0]    ptr_q, ptr_d;     // next free byte in the block (0..64)
  logic [60:0]   cnt_q, cnt_d;     // message byte count; bit length = cnt*8
  logic          first_q, first_d; // next emitted block is the first of its message
  logic          last_q, last_d;   // block being emitted is the final one
  logic          pad2_q, pad2_d;   // an extra padding block follows this emit
  logic          pad80_q, pad80_d; // that extra block still needs the 0x80 marker
  logic          err_q, err_d;

  // Mask with the n most-significant (earliest) byte lanes set.
  function automatic logic [BYTES-1:0] lead_mask(input int n);
    logic [BYTES-1:0] m;
    m = '0;
    for (int i = 0; i < BYTES; i++) begin
      if (i < n) m[BYTES-1-i] = 1'b1;
    end
    return m;
  endfunction

  logic          keep_full;
  logic          keep_last_ok;
  logic [KW-1:0] keep_n;
  logic          beat_acc;
  logic          beat_bad;
  logic [KW-1:0] beat_n;

  assign s_axis_tready = (state_q == ST_FILL) & ~rst;
  assign beat_acc      = s_axis_tvalid & s_axis_tready;

  // Classify tkeep: full beat, or a legal leading-ones tail pattern and its byte count.
  always_comb begin
    keep_full    = &s_axis_tkeep;
    keep_last_ok = 1'b0;
    keep_n       = '0;
    for (int n = 0; n <= BYTES; n++) begin
      if (s_axis_tkeep == lead_mask(n)) begin
        keep_last_ok = 1'b1;
        keep_n       = KW'(n);
      end
    end
  end

  // Bytes taken from the current beat; an illegal pattern contributes nothing.
  always_comb begin
    beat_bad = 1'b0;
    beat_n   = '0;
    if (s_axis_tlast) begin
      beat_bad = ~keep_last_ok;
      beat_n   = keep_last_ok ? keep_n : '0;
    end else begin
      beat_bad = ~keep_full;
      beat_n   = keep_full ? KW'(BYTES) : '0;
    end
  end

  // Next-state and datapath: packing, padding placement and block hand-off.
  always_comb begin
    state_d = state_q;
    buf_d   = buf_q;
    ptr_d   = ptr_q;
    cnt_d   = cnt_q;
    first_d = first_q;
    last_d  = last_q;
    pad2_d  = pad2_q;
    pad80_d = pad80_q;
    err_d   = 1'b0;

    unique case (state_q)
      ST_FILL: begin
        if (beat_acc) begin
          err_d = beat_bad;
          for (int j = 0; j < BYTES; j++) begin
            if (j < int'(beat_n)) begin
              buf_d[511 - 8*(int'(ptr_q[5:0]) + j) -: 8] = s_axis_tdata[DATA_W-1-8*j -: 8];
            end
          end
          ptr_d = ptr_q + 7'(beat_n);
          cnt_d = cnt_q + 61'(beat_n);
          if (s_axis_tlast) begin
            if (ptr_d == 7'd64) begin
              // Block filled exactly: send it raw, marker and length go in a new block.
              state_d = ST_EMIT;
              last_d  = 1'b0;
              pad2_d  = 1'b1;
              pad80_d = 1'b1;
            end else begin
              state_d = ST_PAD;
            end
          end else if (ptr_d == 7'd64) begin
            state_d = ST_EMIT;
            last_d  = 1'b0;
            pad2_d  = 1'b0;
          end
        end
      end

      ST_PAD: begin
        buf_d[511 - 8*int'(ptr_q[5:0]) -: 8] = 8'h80;
        if (ptr_q <= 7'd55) begin
          buf_d[63:0] = {cnt_q, 3'b000};
          last_d      = 1'b1;
          pad2_d      = 1'b0;
        end else begin
          // No room for the length field: it moves to an extra block.
          last_d  = 1'b0;
          pad2_d  = 1'b1;
          pad80_d = 1'b0;
        end
        state_d = ST_EMIT;
      end

      ST_PAD2: begin
        buf_d = '0;
        if (pad80_q) buf_d[511:504] = 8'h80;
        buf_d[63:0] = {cnt_q, 3'b000};
        last_d  = 1'b1;
        pad2_d  = 1'b0;
        pad80_d = 1'b0;
        state_d = ST_EMIT;
      end

      ST_EMIT: begin
        if (blk_ready) begin
          buf_d   = '0;
          ptr_d   = '0;
          first_d = 1'b0;
          if (last_q) begin
            cnt_d   = '0;
            first_d = 1'b1;
            last_d  = 1'b0;
            state_d = ST_FILL;
          end else if (pad2_q) begin
            state_d = ST_PAD2;
          end else begin
            state_d = ST_FILL;
          end
        end
      end

      default: state_d = ST_FILL;
    endcase
  end

  // State and datapath registers, asynchronously cleared.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= ST_FILL;
      buf_q   <= '0;
      ptr_q   <= '0;
      cnt_q   <= '0;
      first_q <= 1'b1;
      last_q  <= 1'b0;
      pad2_q  <= 1'b0;
      pad80_q <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      buf_q   <= buf_d;
      ptr_q   <= ptr_d;
      cnt_q   <= cnt_d;
      first_q <= first_d;
      last_q  <= last_d;
      pad2_q  <= pad2_d;
      pad80_q <= pad80_d;
      err_q   <= err_d;
    end
  end

  assign blk_valid = (state_q == ST_EMIT);
  assign blk_data  = buf_q;
  assign blk_first = blk_valid & first_q;
  assign blk_last  = blk_valid & last_q;
  assign err_keep  = err_q;

endmodule

// File: tb/tb_sm3_axis_pad.sv
// tb_sm3_axis_pad: scoreboard bench. Each message's expected padded blocks are
// computed from the byte list and queued; a monitor pops one per block handshake.
module tb_sm3_axis_pad;

  localparam int DW = 32;
  localparam int B  = DW / 8;

  logic           clk = 1'b0;
  logic           rst;
  logic [DW-1:0]  s_axis_tdata;
  logic [B-1:0]   s_axis_tkeep;
  logic           s_axis_tlast;
  logic           s_axis_tvalid;
  logic           s_axis_tready;
  logic [511:0]   blk_data;
  logic           blk_valid;
  logic           blk_ready;
  logic           blk_first;
  logic           blk_last;
  logic           err_keep;

  sm3_axis_pad #(.DATA_W(DW)) dut (
    .clk           (clk),
    .rst           (rst),
    .s_axis_tdata  (s_axis_tdata),
    .s_axis_tkeep  (s_axis_tkeep),
    .s_axis_tlast  (s_axis_tlast),
    .s_axis_tvalid (s_axis_tvalid),
    .s_axis_tready (s_axis_tready),
    .blk_data      (blk_data),
    .blk_valid     (blk_valid),
    .blk_ready     (blk_ready),
    .blk_first     (blk_first),
    .blk_last      (blk_last),
    .err_keep      (err_keep)
  );

  always #5 clk = ~clk;

  typedef logic [7:0] bytes_t[$];
  typedef struct {
    logic [511:0] d;
    logic         f;
    logic         l;
  } exp_t;

  exp_t   exp_q[$];
  int     total = 0;
  int     bad = 0;
  int     err_exp = 0;
  int     err_seen = 0;
  int     blk_no = 0;
  bit     force_low = 1'b0;
  bit     stalled = 1'b0;
  logic [511:0] held_d;
  logic         held_f, held_l;

  task automatic chk(input string name, input logic [511:0] act, input logic [511:0] req);
    total++;
    if (act !== req) begin
      bad++;
      $display("FAIL %s: got %h required %h", name, act, req);
    end
  endtask

  task automatic chk1(input string name, input logic act, input logic req);
    total++;
    if (act !== req) begin
      bad++;
      $display("FAIL %s: got %0b required %0b", name, act, req);
    end
  endtask

  task automatic finish_now();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  endtask

  function automatic logic [B-1:0] lead_mask(input int n);
    logic [B-1:0] m;
    m = '0;
    for (int i = 0; i < n; i++) m[B-1-i] = 1'b1;
    return m;
  endfunction

  function automatic bit legal_tail(input logic [B-1:0] k);
    for (int n = 0; n <= B; n++) if (k == lead_mask(n)) return 1'b1;
    return 1'b0;
  endfunction

  // Reference: message || 0x80 || zeros || 64-bit bit length, cut into 64-byte blocks.
  task automatic push_expected(input bytes_t msg);
    bytes_t       p;
    logic [63:0]  len;
    exp_t         e;
    int           nblk;
    p = msg;
    p.push_back(8'h80);
    while ((p.size() % 64) != 56) p.push_back(8'h00);
    len = 64'(msg.size()) * 64'd8;
    for (int i = 7; i >= 0; i--) p.push_back(len[8*i +: 8]);
    nblk = p.size() / 64;
    for (int b = 0; b < nblk; b++) begin
      e.d = '0;
      for (int k = 0; k < 64; k++) e.d[511 - 8*k -: 8] = p[b*64 + k];
      e.f = (b == 0);
      e.l = (b == nblk - 1);
      exp_q.push_back(e);
    end
  endtask

  function automatic logic [DW-1:0] pack_beat(input bytes_t msg, input int idx, input int cnt);
    logic [DW-1:0] d;
    d = DW'($urandom);
    for (int j = 0; j < cnt; j++) d[DW-1-8*j -: 8] = msg[idx + j];
    return d;
  endfunction

  // Present one beat and hold it until accepted; called and returns at posedge+1.
  task automatic send_beat(input logic [DW-1:0] d, input logic [B-1:0] k, input logic l);
    bit acc;
    acc = 1'b0;
    s_axis_tdata  = d;
    s_axis_tkeep  = k;
    s_axis_tlast  = l;
    s_axis_tvalid = 1'b1;
    for (int c = 0; c < 3000 && !acc; c++) begin
      @(negedge clk);
      acc = s_axis_tready;
      @(posedge clk);
      #1;
    end
    s_axis_tvalid = 1'b0;
    s_axis_tdata  = DW'($urandom);
    s_axis_tkeep  = '0;
    s_axis_tlast  = 1'b0;
    if (!acc) begin
      total++;
      bad++;
      $display("FAIL beat_accept: tready stayed 0, required 1 within 3000 cycles");
      finish_now();
    end
  endtask

  task automatic gap();
    int g;
    g = $urandom_range(0, 2);
    repeat (g) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic send_msg(input bytes_t msg, input int n_bad_mid, input bit bad_last);
    int idx, n, rem, bad_left;
    logic [B-1:0] k;
    push_expected(msg);
    idx = 0;
    n = msg.size();
    bad_left = n_bad_mid;
    while (1) begin
      rem = n - idx;
      if (bad_left > 0 && ($urandom_range(0, 2) == 0 || rem <= B)) begin
        send_beat(DW'($urandom), B'($urandom_range(0, (1 << B) - 2)), 1'b0);
        err_exp++;
        bad_left--;
        gap();
        continue;
      end
      if (rem > B || (rem == B && (bad_last || $urandom_range(0, 1) == 1))) begin
        send_beat(pack_beat(msg, idx, B), '1, 1'b0);
        idx += B;
        gap();
        continue;
      end
      break;
    end
    if (bad_last) begin
      do k = B'($urandom_range(0, (1 << B) - 1)); while (legal_tail(k));
      send_beat(DW'($urandom), k, 1'b1);
      err_exp++;
    end else begin
      send_beat(pack_beat(msg, idx, rem), lead_mask(rem), 1'b1);
    end
  endtask

  task automatic wait_drain();
    for (int c = 0; c < 5000 && exp_q.size() != 0; c++) @(posedge clk);
    if (exp_q.size() != 0) begin
      total++;
      bad++;
      $display("FAIL drain: %0d blocks outstanding, required 0", exp_q.size());
    end
    repeat (4) @(posedge clk);
    #1;
  endtask

  // Core-side ready: random, or held low to stall an emitted block.
  initial begin
    blk_ready = 1'b0;
    forever begin
      @(posedge clk);
      #1;
      blk_ready = force_low ? 1'b0 : ($urandom_range(0, 3) != 0);
    end
  end

  // Monitor: block hand-offs against the scoreboard, stall stability, error pulses.
  always @(negedge clk) begin
    if (rst) begin
      stalled = 1'b0;
    end else begin
      if (err_keep) err_seen++;
      if (blk_valid) begin
        chk1("tready_in_emit", s_axis_tready, 1'b0);
        if (stalled) begin
          chk("stall_data", blk_data, held_d);
          chk1("stall_first", blk_first, held_f);
          chk1("stall_last", blk_last, held_l);
        end
        if (blk_ready) begin
          if (exp_q.size() == 0) begin
            total++;
            bad++;
            $display("FAIL unexpected_block: got W0=%h, required no block", blk_data[511:480]);
          end else begin
            exp_t e;
            e = exp_q.pop_front();
            chk("blk_data", blk_data, e.d);
            chk1("blk_first", blk_first, e.f);
            chk1("blk_last", blk_last, e.l);
            $display("block %0d first=%0b last=%0b W0=%h W15=%h", blk_no, blk_first, blk_last,
                     blk_data[511:480], blk_data[31:0]);
            blk_no++;
          end
          stalled = 1'b0;
        end else begin
          stalled = 1'b1;
          held_d  = blk_data;
          held_f  = blk_first;
          held_l  = blk_last;
        end
      end else begin
        stalled = 1'b0;
      end
    end
  end

  initial begin
    bytes_t msg;
    int     len;
    rst           = 1'b1;
    s_axis_tdata  = '0;
    s_axis_tkeep  = '0;
    s_axis_tlast  = 1'b0;
    s_axis_tvalid = 1'b0;

    // Reset state.
    repeat (3) @(posedge clk);
    #1;
    chk1("rst_tready", s_axis_tready, 1'b0);
    chk1("rst_valid", blk_valid, 1'b0);
    chk("rst_data", blk_data, 512'd0);
    chk1("rst_err", err_keep, 1'b0);
    rst = 1'b0;
    @(posedge clk);
    #1;
    chk1("fill_tready", s_axis_tready, 1'b1);

    // "abc" with latency and absolute-value checks.
    msg = '{8'h61, 8'h62, 8'h63};
    push_expected(msg);
    send_beat(32'h61626300, 4'b1110, 1'b1);
    @(negedge clk);
    chk1("abc_valid_pad_cycle", blk_valid, 1'b0);
    @(negedge clk);
    chk1("abc_valid_2cyc", blk_valid, 1'b1);
    chk("abc_block", blk_data, {32'h61626380, 416'd0, 64'h18});
    chk1("abc_first", blk_first, 1'b1);
    chk1("abc_last", blk_last, 1'b1);
    wait_drain();

    // Empty message.
    msg = {};
    send_msg(msg, 0, 1'b0);
    wait_drain();

    // 56-byte message: length spills to a second block.
    msg = {};
    for (int i = 0; i < 56; i++) msg.push_back(8'h61 + 8'(i % 4));
    send_msg(msg, 0, 1'b0);
    wait_drain();

    // 64-byte message: exact block, then marker+length block.
    for (int r = 0; r < 2; r++) begin
      msg = {};
      for (int i = 0; i < 64; i++) msg.push_back(8'($urandom));
      send_msg(msg, 0, 1'b0);
      wait_drain();
    end

    // Core stall of 20 cycles during EMIT plus a dropped illegal beat.
    msg = {};
    for (int i = 0; i < 100; i++) msg.push_back(8'($urandom));
    force_low = 1'b1;
    fork
      send_msg(msg, 1, 1'b0);
      begin
        for (int c = 0; c < 2000 && !blk_valid; c++) @(negedge clk);
        chk1("stall_valid_seen", blk_valid, 1'b1);
        repeat (20) @(posedge clk);
        force_low = 1'b0;
      end
    join
    wait_drain();

    // Reset mid-message (ptr=24), then "abc" must come out clean.
    for (int i = 0; i < 6; i++) send_beat(DW'($urandom), '1, 1'b0);
    @(negedge clk);
    #2;
    rst = 1'b1;
    #1;
    chk1("midrst_tready", s_axis_tready, 1'b0);
    chk1("midrst_valid", blk_valid, 1'b0);
    chk("midrst_data", blk_data, 512'd0);
    chk1("midrst_err", err_keep, 1'b0);
    @(posedge clk);
    @(posedge clk);
    #1;
    rst = 1'b0;
    msg = '{8'h61, 8'h62, 8'h63};
    send_msg(msg, 0, 1'b0);
    wait_drain();

    // Randomized messages with boundary-biased lengths and illegal beats.
    for (int m = 0; m < 30; m++) begin
      int picks[9] = '{55, 56, 57, 63, 64, 65, 119, 120, 128};
      bit bl;
      len = ($urandom_range(0, 2) == 0) ? picks[$urandom_range(0, 8)] : $urandom_range(0, 150);
      bl = ($urandom_range(0, 5) == 0);
      if (bl) len = len - (len % B);
      msg = {};
      for (int i = 0; i < len; i++) msg.push_back(8'($urandom));
      send_msg(msg, $urandom_range(0, 2), bl);
      gap();
    end
    wait_drain();

    chk("err_keep_pulses", 512'(err_seen), 512'(err_exp));
    finish_now();
  end

endmodule
